// File: rtl/aib_avmm_cfg_master.sv
// aib_avmm_cfg_master: queued AVMM config master, one transaction outstanding; read timeout optional via AVMM_RD_TIMEOUT_EN
module aib_avmm_cfg_master #(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_cfg_avmm_clk,
  input  logic        i_cfg_avmm_rst,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_write,
  input  logic [16:0] i_cmd_addr,
  input  logic [3:0]  i_cmd_byte_en,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_cmd_ready,
  output logic        o_cfg_avmm_write,
  output logic        o_cfg_avmm_read,
  output logic [16:0] o_cfg_avmm_addr,
  output logic [3:0]  o_cfg_avmm_byte_en,
  output logic [31:0] o_cfg_avmm_wdata,
  input  logic        i_cfg_avmm_waitreq,
  input  logic        i_cfg_avmm_rdatavld,
  input  logic [31:0] i_cfg_avmm_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_busy
);
  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(CMD_DEPTH);
  typedef enum logic [1:0] {IDLE, XFER, RDWAIT} state_t;
  state_t state, state_nxt;
  logic [53:0] mem [CMD_DEPTH];
  logic [53:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, accept, rsp_ok, tmo;
  assign o_cmd_ready = count < DEPTH;
  assign push = i_cmd_valid && o_cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign head = mem[rd_ptr];
  assign accept = state == XFER && !i_cfg_avmm_waitreq;
  assign rsp_ok = state == RDWAIT && i_cfg_avmm_rdatavld;
  assign o_busy = state != IDLE || count != '0;
  // Command storage: {write, addr, byte_en, wdata}
  always_ff @(posedge i_cfg_avmm_clk)
    if (push) mem[wr_ptr] <= {i_cmd_write, i_cmd_addr, i_cmd_byte_en, i_cmd_wdata};
  // FIFO pointers wrap naturally at the power-of-two depth
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst)
    if (i_cfg_avmm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
`ifdef AVMM_RD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;
  assign tmo = state == RDWAIT && !i_cfg_avmm_rdatavld && tmo_cnt == TMO_LAST;
  // Wait counter restarts on acceptance and ticks once per RDWAIT cycle
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst)
    if (i_cfg_avmm_rst) tmo_cnt <= '0;
    else if (accept) tmo_cnt <= '0;
    else if (state == RDWAIT) tmo_cnt <= tmo_cnt + 16'd1;
  // Error flag rides along with the timeout response pulse only
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst)
    if (i_cfg_avmm_rst) o_rsp_err <= 1'b0;
    else o_rsp_err <= tmo;
`else
  assign tmo = 1'b0;
  assign o_rsp_err = 1'b0;
`endif
  // State register
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst)
    if (i_cfg_avmm_rst) state <= IDLE;
    else state <= state_nxt;
  // Next state: issue from IDLE, complete in XFER, reads wait for data in RDWAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = XFER;
      XFER:    if (!i_cfg_avmm_waitreq) state_nxt = o_cfg_avmm_write ? IDLE : RDWAIT;
      RDWAIT:  if (rsp_ok || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // AVMM master outputs held from pop until the slave accepts; response capture
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst)
    if (i_cfg_avmm_rst) begin
      o_cfg_avmm_write   <= 1'b0;
      o_cfg_avmm_read    <= 1'b0;
      o_cfg_avmm_addr    <= '0;
      o_cfg_avmm_byte_en <= '0;
      o_cfg_avmm_wdata   <= '0;
      o_rsp_valid        <= 1'b0;
      o_rsp_data         <= '0;
    end else begin
      o_rsp_valid <= rsp_ok || tmo;
      if (pop) begin
        o_cfg_avmm_write <= head[53];
        o_cfg_avmm_read  <= !head[53];
        {o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_wdata} <= head[52:0];
      end else if (accept) begin
        o_cfg_avmm_write <= 1'b0;
        o_cfg_avmm_read  <= 1'b0;
      end
      if (rsp_ok || tmo) o_rsp_data <= rsp_ok ? i_cfg_avmm_rdata : 32'h0;
    end
endmodule
